// File: rtl/irq_fetch_unit_pkg.sv
// Shared definitions for the interrupt-capable fetch unit: FSM encoding,
// default addresses and a counter-width helper.
package irq_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_VECTOR  = 2'd2,
    ST_HANDLER = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h0000_0100;
  // Instruction the IF/ID register loads while flush is high.
  localparam logic [31:0] NOP_INSN           = 32'h0000_0013;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $unsigned($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/irq_fetch_unit_btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and a
// one-cycle strobe on each accepted 0->1 change of the debounced level.
module btn_conditioner
  import irq_fetch_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn1,
  output logic o_rise
);

  localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn1;
  logic          r_btn1_d;
  logic [CW-1:0] r_cnt;

  // A level change is accepted only after it has been seen for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_btn1   <= 1'b0;
      r_btn1_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_btn;
      r_sync2  <= r_sync1;
      r_btn1_d <= r_btn1;
      if (r_sync2 != r_btn1) begin
        if (r_cnt == CNT_LAST) begin
          r_btn1 <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + CNT_ONE;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_btn1 = r_btn1;
  assign o_rise = r_btn1 & ~r_btn1_d;

endmodule

// File: rtl/irq_fetch_unit.sv
// Fetch-stage PC unit: owns the PC, drains the pipeline on a debounced button
// interrupt, vectors to a fixed handler and restores the saved PC on mret.
module irq_fetch_unit
  import irq_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter logic [31:0] IRQ_VECTOR      = DEFAULT_IRQ_VECTOR,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        mret,
  output logic [31:0] pc,
  output logic        flush,
  output logic        iled,
  output logic        btn1,
  output logic [31:0] epc
);

  localparam int unsigned   DW         = cnt_width(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_epc;
  logic [31:0]   w_epc_nxt;
  logic [DW-1:0] r_drain_cnt;
  logic [DW-1:0] w_drain_cnt_nxt;
  logic          r_iled;
  logic          w_iled_nxt;
  logic          r_pending;
  logic          w_consume;
  logic          w_flush;
  logic          w_rise;
  logic          w_btn1;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_btn  (btn),
    .o_btn1 (w_btn1),
    .o_rise (w_rise)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_epc_nxt       = r_epc;
    w_iled_nxt      = r_iled;
    w_drain_cnt_nxt = r_drain_cnt;
    w_consume       = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_pc_nxt = stall ? r_pc : next_pc;
        if (r_pending && !stall) begin
          w_state_nxt     = ST_DRAIN;
          w_epc_nxt       = next_pc;
          w_consume       = 1'b1;
          w_drain_cnt_nxt = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // A branch resolving while older instructions retire replaces the return address.
        w_flush   = 1'b1;
        w_epc_nxt = redirect ? next_pc : r_epc;
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt     = ST_VECTOR;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DRAIN_ONE;
        end
      end
      ST_VECTOR: begin
        w_flush     = 1'b1;
        w_pc_nxt    = IRQ_VECTOR;
        w_iled_nxt  = 1'b1;
        w_state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (mret) begin
          w_flush     = 1'b1;
          w_pc_nxt    = r_epc;
          w_iled_nxt  = 1'b0;
          w_state_nxt = ST_RUN;
        end else begin
          w_pc_nxt    = stall ? r_pc : next_pc;
          w_iled_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // A new edge wins over consumption so a press landing on DRAIN entry is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_epc       <= 32'h0000_0000;
      r_iled      <= 1'b0;
      r_pending   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_epc       <= w_epc_nxt;
      r_iled      <= w_iled_nxt;
      r_pending   <= w_rise | (r_pending & ~w_consume);
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  assign pc    = r_pc;
  assign epc   = r_epc;
  assign iled  = r_iled;
  assign flush = w_flush;
  assign btn1  = w_btn1;

endmodule

// File: tb/tb_irq_fetch_unit.sv
// Directed bench for irq_fetch_unit: a cycle model driven from the stimulus
// task, a per-cycle compare process and hand-computed checkpoints.
module tb_irq_fetch_unit;

  localparam int          D_CYC  = 4;
  localparam int          DR_CYC = 3;
  localparam logic [31:0] IRQ_A  = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        btn;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic        mret;
  logic [31:0] pc;
  logic        flush;
  logic        iled;
  logic        btn1;
  logic [31:0] epc;

  int n_chk;
  int n_err;
  bit chk_en;

  // model state
  logic [31:0] m_pc, m_epc;
  bit          m_iled, m_btn1, m_btn1_d, m_s1, m_s2, m_pending, m_inh;
  int          m_run, m_bub;

  irq_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .next_pc  (next_pc),
    .redirect (redirect),
    .stall    (stall),
    .mret     (mret),
    .pc       (pc),
    .flush    (flush),
    .iled     (iled),
    .btn1     (btn1),
    .epc      (epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_iled = 0; m_btn1 = 0; m_btn1_d = 0;
    m_s1 = 0; m_s2 = 0; m_run = 0; m_pending = 0; m_inh = 0; m_bub = 0;
  endtask

  // One clock edge of the abstract model; m_bub counts the remaining flush
  // cycles between interrupt acceptance and landing on the vector.
  task automatic model_step();
    bit rise, consume;
    rise    = m_btn1 && !m_btn1_d;
    consume = 0;
    if (m_bub > 0) begin
      if (m_bub > 1 && redirect) m_epc = next_pc;
      m_bub--;
      if (m_bub == 0) begin m_pc = IRQ_A; m_iled = 1; m_inh = 1; end
    end else if (m_inh && mret) begin
      m_pc = m_epc; m_iled = 0; m_inh = 0;
    end else begin
      if (!m_inh && m_pending && !stall) begin
        m_epc = next_pc; m_bub = DR_CYC + 1; consume = 1;
      end
      if (!stall) m_pc = next_pc;
    end
    m_pending = rise || (m_pending && !consume);
    m_btn1_d  = m_btn1;
    if (m_s2 != m_btn1) begin
      m_run++;
      if (m_run == D_CYC) begin m_btn1 = m_s2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic tick(input logic [31:0] np, input logic rd, input logic st, input logic mr);
    next_pc = np; redirect = rd; stall = st; mret = mr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fetch();
    tick(m_pc + 32'd4, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc",    pc,    m_pc);
      check("cyc_epc",   epc,   m_epc);
      check("cyc_iled",  iled,  m_iled);
      check("cyc_btn1",  btn1,  m_btn1);
      check("cyc_flush", flush, (m_bub > 0) || (m_inh && mret));
    end
  end

  initial begin
    int k;
    int n;
    n_chk = 0; n_err = 0; chk_en = 0;
    clk = 0; reset = 0; btn = 0; next_pc = 32'h40; redirect = 0; stall = 0; mret = 0;
    model_reset();
    #1 reset = 1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_iled", iled, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_btn1", btn1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 0; chk_en = 1;
    tick(32'h40, 1'b0, 1'b0, 1'b0);
    check("rel_pc", pc, 32'h40);
    tick(32'h44, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle
    #2 reset = 1; model_reset();
    #1;
    check("async_pc", pc, 32'h0);
    check("async_iled", iled, 1'b0);
    check("async_flush", flush, 1'b0);
    @(posedge clk); #1;
    check("hold_pc", pc, 32'h0);
    reset = 0;

    // normal fetch with a stall at 0x8, then an ignored mret in RUN
    tick(32'h4, 1'b0, 1'b0, 1'b0);  check("fetch_0", pc, 32'h4);
    tick(32'h8, 1'b0, 1'b0, 1'b0);  check("fetch_1", pc, 32'h8);
    tick(32'hC, 1'b0, 1'b1, 1'b0);  check("fetch_2", pc, 32'h8);
    tick(32'hC, 1'b0, 1'b0, 1'b0);  check("fetch_3", pc, 32'hC);
    tick(32'h10, 1'b0, 1'b0, 1'b0); check("fetch_4", pc, 32'h10);
    tick(32'h14, 1'b0, 1'b0, 1'b1);
    check("mret_run_pc", pc, 32'h14);
    check("mret_run_flush", flush, 1'b0);

    // park at 0x20 under stall, then a 2-cycle glitch
    tick(32'h20, 1'b1, 1'b0, 1'b0);
    check("park_pc", pc, 32'h20);
    btn = 1;
    repeat (2) tick(32'h24, 1'b0, 1'b1, 1'b0);
    btn = 0;
    repeat (5) tick(32'h24, 1'b0, 1'b1, 1'b0);
    check("glitch_btn1", btn1, 1'b0);
    check("glitch_iled", iled, 1'b0);

    // stable press: btn1 rises six edges after the press
    btn = 1; k = 0;
    while (btn1 !== 1'b1 && k < 20) begin tick(32'h24, 1'b0, 1'b1, 1'b0); k++; end
    check("btn1_lat", k, 6);
    repeat (2) tick(32'h24, 1'b0, 1'b1, 1'b0);
    check("stall_hold_flush", flush, 1'b0);
    tick(32'h24, 1'b0, 1'b0, 1'b0);
    check("entry_flush", flush, 1'b1);
    check("entry_epc", epc, 32'h24);
    n = 0;
    while (flush === 1'b1 && n < 10) begin n++; tick(32'h24, 1'b0, (n == 2), 1'b0); end
    check("flush_len", n, 4);
    check("vec_pc", pc, IRQ_A);
    check("vec_iled", iled, 1'b1);
    check("vec_epc", epc, 32'h24);

    // handler, then return
    btn = 0;
    fetch(); fetch();
    check("hdl_pc", pc, 32'h108);
    mret = 1; #1;
    check("mret_flush", flush, 1'b1);
    tick(m_pc + 32'd4, 1'b0, 1'b0, 1'b1);
    check("ret_pc", pc, 32'h24);
    check("ret_iled", iled, 1'b0);
    check("ret_flush", flush, 1'b0);

    // second interrupt with a late branch during drain
    k = 0;
    while (btn1 !== 1'b0 && k < 20) begin fetch(); k++; end
    btn = 1; k = 0;
    while (flush !== 1'b1 && k < 30) begin fetch(); k++; end
    check("btn_to_drain", k, 8);
    tick(32'h80, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (flush === 1'b1 && n < 10) begin n++; tick(32'h90, 1'b0, 1'b0, 1'b0); end
    check("br_epc", epc, 32'h80);
    check("br_pc", pc, IRQ_A);
    check("br_iled", iled, 1'b1);

    // mret coinciding with a fresh debounced edge
    btn = 0; k = 0;
    while (btn1 !== 1'b0 && k < 20) begin fetch(); k++; end
    btn = 1; k = 0;
    while (btn1 !== 1'b1 && k < 20) begin fetch(); k++; end
    tick(m_pc + 32'd4, 1'b0, 1'b0, 1'b1);
    check("sim_pc", pc, 32'h80);
    check("sim_iled", iled, 1'b0);
    check("sim_flush", flush, 1'b0);
    tick(32'h84, 1'b0, 1'b0, 1'b0);
    check("sim_drain_flush", flush, 1'b1);
    check("sim_drain_pc", pc, 32'h84);
    check("sim_drain_epc", epc, 32'h84);
    tick(32'h88, 1'b0, 1'b0, 1'b0);

    // reset in the middle of DRAIN
    #2 reset = 1; model_reset();
    #1;
    check("drain_rst_pc", pc, 32'h0);
    check("drain_rst_flush", flush, 1'b0);
    check("drain_rst_epc", epc, 32'h0);
    @(posedge clk); #1;
    reset = 0; btn = 0;
    repeat (4) fetch();
    check("post_rst_pc", pc, 32'h10);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
